// File: rtl/div_ctrl.sv
// Sequencing controller between the EX stage and a multi-cycle DIV/DIVU unit.
// Latency: HI/LO write strobe two cycles after div_ready_i is first seen in RUN.
// Backpressure: stall_o freezes IF/ID/EX from the accept cycle until WB.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   div_req_i, signed_i        DIV/DIVU request held by EX, signedness
//   op_a_i, op_b_i             dividend / divisor from EX
//   flush_i                    pipeline flush (exception / eret)
//   start_o, annul_o           divider run / abort controls
//   signed_div_o, opdata*_o    latched signedness and operands for the divider
//   div_result_i, div_ready_i  {remainder, quotient} and done from the divider
//   stall_o                    pipeline freeze (only combinational output)
//   hilo_we_o, hi_o, lo_o      HI/LO write strobe, remainder, quotient
//   divzero_o                  qualifies hilo_we_o when the divisor was zero
//   timeout_o                  pulse when the divider was aborted for taking too long
module div_ctrl #(
    parameter int TIMEOUT = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req_i,
    input  logic        signed_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        flush_i,
    output logic        start_o,
    output logic        annul_o,
    output logic        signed_div_o,
    output logic [31:0] opdata1_o,
    output logic [31:0] opdata2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        stall_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        divzero_o,
    output logic        timeout_o
);

    // Counter holds RUN cycles elapsed (0..TIMEOUT-1) and CANCEL cycles (0..1).
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_WB     = 2'd2,
        S_CANCEL = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_dz;

    logic w_accept;
    logic w_run_done;
    logic w_run_tmo;
    logic w_start_nxt;
    logic w_annul_nxt;
    logic w_tmo_nxt;
    logic w_we_nxt;
    logic w_dz_nxt;
    logic w_stall;

    // Flush outranks ready, ready outranks the timeout on the final RUN cycle.
    assign w_accept   = (r_state == S_IDLE) & div_req_i & ~flush_i;
    assign w_run_done = (r_state == S_RUN) & ~flush_i & div_ready_i;
    assign w_run_tmo  = (r_state == S_RUN) & ~flush_i & ~div_ready_i & (r_cnt == CNT_LAST);

    // State register, counter and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_dz         <= 1'b0;
            start_o      <= 1'b0;
            annul_o      <= 1'b0;
            signed_div_o <= 1'b0;
            opdata1_o    <= '0;
            opdata2_o    <= '0;
            hilo_we_o    <= 1'b0;
            hi_o         <= '0;
            lo_o         <= '0;
            divzero_o    <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            r_state   <= w_next;
            start_o   <= w_start_nxt;
            annul_o   <= w_annul_nxt;
            timeout_o <= w_tmo_nxt;
            hilo_we_o <= w_we_nxt;
            divzero_o <= w_dz_nxt;

            if (w_accept) begin
                opdata1_o    <= op_a_i;
                opdata2_o    <= op_b_i;
                signed_div_o <= signed_i;
                r_dz         <= (op_b_i == 32'd0);
            end

            if (w_run_done) begin
                hi_o <= div_result_i[63:32];
                lo_o <= div_result_i[31:0];
            end

            // Restart from zero whenever RUN or CANCEL is entered.
            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_cnt <= (w_next == S_RUN) ? r_cnt + CW'(1) : '0;
            end else if (r_state == S_CANCEL) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_RUN;
            S_RUN: begin
                if (flush_i || w_run_tmo) w_next = S_CANCEL;
                else if (div_ready_i)     w_next = S_WB;
            end
            S_WB:     w_next = S_IDLE;
            // Two cycles with start low so the divider falls back to idle.
            S_CANCEL: if (r_cnt == CW'(1)) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, plus stall.
    always_comb begin
        w_start_nxt = (w_next == S_RUN);
        w_annul_nxt = 1'b0;
        w_tmo_nxt   = 1'b0;
        w_we_nxt    = 1'b0;
        w_dz_nxt    = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: w_stall = w_accept;
            S_RUN: begin
                w_stall     = 1'b1;
                w_annul_nxt = (w_next == S_CANCEL);
                w_tmo_nxt   = w_run_tmo;
            end
            // EX advances at the end of WB; a late flush drops the write.
            S_WB: begin
                w_we_nxt = ~flush_i;
                w_dz_nxt = ~flush_i & r_dz;
            end
            S_CANCEL: w_stall = div_req_i;
            default: w_stall = 1'b0;
        endcase
    end

    assign stall_o = rst & w_stall;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

    localparam int TMO = 48;

    logic        clk;
    logic        rst;
    logic        div_req_i;
    logic        signed_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        flush_i;
    logic        start_o;
    logic        annul_o;
    logic        signed_div_o;
    logic [31:0] opdata1_o;
    logic [31:0] opdata2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        stall_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        divzero_o;
    logic        timeout_o;

    div_ctrl #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_req_i    (div_req_i),
        .signed_i     (signed_i),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .flush_i      (flush_i),
        .start_o      (start_o),
        .annul_o      (annul_o),
        .signed_div_o (signed_div_o),
        .opdata1_o    (opdata1_o),
        .opdata2_o    (opdata2_o),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i),
        .stall_o      (stall_o),
        .hilo_we_o    (hilo_we_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .divzero_o    (divzero_o),
        .timeout_o    (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // kind: 0 = HI/LO write, 1 = flush annul, 2 = timeout annul
    typedef struct {
        int          kind;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          exp_cyc;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Architectural MIPS division: truncating quotient, remainder takes the
    // dividend's sign; zero divisor yields zeros.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        int sa;
        int sbv;
        int q;
        int r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa  = a;
            sbv = b;
            q   = sa / sbv;
            r   = sa % sbv;
            return {32'(r), 32'(q)};
        end
        return {a % b, a / b};
    endfunction

    // Stand-in divider: ready div_lat cycles after start, held until start drops.
    int dcnt;
    int div_lat   = 5;
    bit force_low = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dcnt         <= 0;
            div_ready_i  <= 1'b0;
            div_result_i <= 64'd0;
        end else if (!start_o) begin
            dcnt        <= 0;
            div_ready_i <= 1'b0;
        end else if (dcnt >= div_lat) begin
            div_ready_i  <= !force_low;
            div_result_i <= ref_div(opdata1_o, opdata2_o, signed_div_o);
        end else begin
            dcnt <= dcnt + 1;
        end
    end

    // Monitor: pops an expectation whenever the DUT reports a write or abort.
    initial begin : monitor
        exp_t e;
        int   ka;
        bit   prev_start;
        bit   rdy_seen;
        int   rdy_cyc;
        int   start_cyc;
        prev_start = 1'b0;
        rdy_seen   = 1'b0;
        rdy_cyc    = 0;
        start_cyc  = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_start = 1'b0;
                rdy_seen   = 1'b0;
            end else begin
                if (start_o && !prev_start) begin
                    start_cyc = cyc;
                    check("quiet_on_start_rise", {annul_o, hilo_we_o, timeout_o}, 0);
                end
                if (start_o) check("stall_in_run", stall_o, 1);
                if (div_ready_i && start_o && !flush_i && !rdy_seen) begin
                    rdy_seen = 1'b1;
                    rdy_cyc  = cyc;
                end
                if (hilo_we_o || annul_o || timeout_o) begin
                    if (hilo_we_o) ka = (annul_o || timeout_o) ? 3 : 0;
                    else if (annul_o) ka = timeout_o ? 2 : 1;
                    else ka = 4;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)",
                                 ka, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("event_kind", ka, e.kind);
                        if (e.kind == 0) begin
                            check("hi", hi_o, e.hi);
                            check("lo", lo_o, e.lo);
                            check("divzero", divzero_o, e.dz);
                            check("hilo_we_latency", rdy_seen ? cyc - rdy_cyc : -1, 2);
                        end
                        if (e.kind == 2) check("timeout_latency", cyc - start_cyc, TMO);
                        if (e.exp_cyc >= 0) check("annul_cycle", cyc, e.exp_cyc);
                    end
                    rdy_seen = 1'b0;
                end
                prev_start = start_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // EX holds the request until the cycle stall drops (WB), then advances.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input int lat, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input int exp_start);
        exp_t e;
        bit   saw_start;
        bit   done;
        saw_start = 1'b0;
        done      = 1'b0;
        div_lat   = lat;
        op_a_i    = a;
        op_b_i    = b;
        signed_i  = sgn;
        div_req_i = 1'b1;
        e.kind = 0; e.hi = ehi; e.lo = elo; e.dz = edz; e.exp_cyc = -1;
        sb.push_back(e);
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (start_o && !saw_start) begin
                saw_start = 1'b1;
                if (exp_start >= 0) check("restart_cycle", cyc, exp_start);
            end
            if (!stall_o) done = 1'b1;
        end
        check("stall_until_wb", {done, saw_start}, 2'b11);
        tick();
        div_req_i = 1'b0;
    endtask

    task automatic wait_start();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (start_o) seen = 1'b1;
        end
        check("start_seen", seen, 1);
    endtask

    task automatic random_ops(input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        s;
            logic [63:0] r;
            int          pick;
            a    = $urandom;
            pick = $urandom_range(0, 7);
            if (pick == 0) b = 32'd0;
            else if (pick < 4) b = 32'($urandom_range(1, 15));
            else b = $urandom;
            s = 1'($urandom_range(0, 1));
            if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            r = ref_div(a, b, s);
            repeat ($urandom_range(0, 2)) tick();
            run_op(a, b, s, $urandom_range(0, 30), r[63:32], r[31:0], (b == 32'd0), -1);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        exp_t e;
        int   fcyc;
        bit   seen;
        rst = 1'b1; div_req_i = 1'b0; signed_i = 1'b0; flush_i = 1'b0;
        op_a_i = 32'd0; op_b_i = 32'd0;
        #2 rst = 1'b0;
        div_req_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {start_o, annul_o, signed_div_o, hilo_we_o, divzero_o, timeout_o,
                           stall_o}, 0);
        check("rst_opdata", {opdata1_o, opdata2_o}, 0);
        check("rst_hilo", {hi_o, lo_o}, 0);
        div_req_i = 1'b0;
        rst = 1'b1;
        tick();

        // Directed cases.
        run_op(32'd100, 32'd7, 1'b0, 6, 32'd2, 32'd14, 1'b0, -1);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1);
        run_op(32'd5, 32'd0, 1'b1, 2, 32'd0, 32'd0, 1'b1, -1);
        run_op(32'd6, 32'd4, 1'b0, 3, 32'd2, 32'd1, 1'b0, -1);
        run_op(32'd8, 32'd3, 1'b0, 2, 32'd2, 32'd2, 1'b0, cyc + 1);

        // Flush on RUN cycle 10, next request held high through CANCEL.
        div_lat = 40; op_a_i = 32'd100; op_b_i = 32'd3; signed_i = 1'b0; div_req_i = 1'b1;
        wait_start();
        repeat (9) tick();
        flush_i = 1'b1;
        fcyc = cyc;
        e.kind = 1; e.hi = 0; e.lo = 0; e.dz = 0; e.exp_cyc = fcyc + 1;
        sb.push_back(e);
        tick();
        flush_i = 1'b0;
        run_op(32'd9, 32'd3, 1'b0, 4, 32'd0, 32'd3, 1'b0, fcyc + 4);

        // Divider never answers: timeout abort.
        force_low = 1'b1; div_lat = 0;
        op_a_i = 32'd77; op_b_i = 32'd5; signed_i = 1'b0; div_req_i = 1'b1;
        e.kind = 2; e.hi = 0; e.lo = 0; e.dz = 0; e.exp_cyc = -1;
        sb.push_back(e);
        seen = 1'b0;
        for (int n = 0; n < TMO + 20 && !seen; n++) begin
            @(negedge clk);
            if (timeout_o) seen = 1'b1;
        end
        check("timeout_seen", seen, 1);
        tick();
        div_req_i = 1'b0;
        force_low = 1'b0;
        tick();
        @(negedge clk);
        check("idle_after_timeout", {start_o, stall_o}, 0);
        tick();

        // Reset in the middle of RUN.
        div_lat = 40; op_a_i = 32'd6; op_b_i = 32'd5; signed_i = 1'b1; div_req_i = 1'b1;
        wait_start();
        repeat (5) tick();
        rst = 1'b0;
        #1;
        check("midrun_rst_ctrl", {start_o, annul_o, signed_div_o, hilo_we_o, divzero_o,
                                  timeout_o, stall_o}, 0);
        check("midrun_rst_opdata", {opdata1_o, opdata2_o}, 0);
        check("midrun_rst_hilo", {hi_o, lo_o}, 0);
        div_req_i = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();

        random_ops(24);

        repeat (5) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 48, maximum RUN-state cycles allowed before the divider operation is aborted.
REQ-002 Reset is asynchronous and active-low; one clock.
REQ-003 Port: clk  in  1  system clock; all state updates on the rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-low reset.
REQ-005 Port: div_req_i  in  1  EX stage holds a valid DIV/DIVU instruction.
REQ-006 Port: signed_i  in  1  1 = DIV (signed), 0 = DIVU.
REQ-007 Port: op_a_i, op_b_i  in  32 each  dividend and divisor from EX.
REQ-008 Port: flush_i  in  1  pipeline flush (exception/eret).
REQ-009 Port: start_o, annul_o, signed_div_o  out  1 each  divider controls.
REQ-010 Port: opdata1_o, opdata2_o  out  32 each  latched operands to the divider.
REQ-011 Port: div_result_i  in  64  divider result, quotient in [31:0], remainder in [63:32].
REQ-012 Port: div_ready_i  in  1  divider done.
REQ-013 Port: stall_o  out  1  freezes IF/ID/EX while a divide is outstanding.
REQ-014 Port: hilo_we_o  out  1  one-cycle HI/LO write strobe.
REQ-015 Port: hi_o, lo_o  out  32 each  remainder and quotient.
REQ-016 Port: divzero_o  out  1  qualifies hilo_we_o when the divisor was zero.
REQ-017 Port: timeout_o  out  1  one-cycle pulse when an operation is aborted by timeout.

Function
REQ-018 The FSM shall have four states: IDLE, RUN, WB and CANCEL; every output except stall_o shall be registered.
REQ-019 IDLE: on div_req_i=1 and flush_i=0, the block shall latch op_a_i, op_b_i and signed_i, set divzero to (op_b_i==0), clear the cycle counter, and move to RUN; stall_o shall be 1 combinationally in that cycle.
REQ-020 RUN: start_o shall be 1, stall_o shall be 1, and opdata/signed outputs shall hold the latched values unchanged.
REQ-021 RUN with div_ready_i=1 and flush_i=0: the block shall register hi_o=div_result_i[63:32] and lo_o=div_result_i[31:0], then go to WB.
REQ-022 WB, lasting exactly one cycle: start_o=0, stall_o=0, hilo_we_o=1 unless flush_i=1 that cycle, divzero_o equal to the latched flag; next state IDLE.
REQ-023 hilo_we_o shall occur exactly 2 cycles after the first cycle div_ready_i is sampled high.
REQ-024 RUN with flush_i=1 (priority over div_ready_i): annul_o=1 for one cycle, start_o=0, no HI/LO write; go to CANCEL.
REQ-025 RUN lasting TIMEOUT cycles without div_ready_i: timeout_o=1 and annul_o=1 for one cycle, start_o=0, no write; go to CANCEL.
REQ-026 CANCEL: start_o=0 for exactly 2 cycles so the divider returns to idle; stall_o=1 if div_req_i=1; new requests shall not be accepted; next state IDLE.
REQ-027 flush_i in IDLE shall suppress acceptance; in CANCEL it has no further effect.
REQ-028 After WB, the next request shall be accepted in the following IDLE cycle (back-to-back); a request held high through WB shall not be double-issued, because EX has advanced.
REQ-029 annul_o, hilo_we_o and timeout_o shall never be asserted in the same cycle as start_o rising.
REQ-030 The block shall not alter operand signs or sign-correct results; the divider performs that.

Reset
REQ-031 While rst=0: state=IDLE, counter=0, and start_o, annul_o, signed_div_o, opdata*, hi_o, lo_o, hilo_we_o, divzero_o and timeout_o shall all be 0; stall_o=0.
REQ-032 Reset asserted mid-RUN shall abandon the operation with no HI/LO write; the bench shall reset the divider together with this block.

Verification
REQ-033 DIVU 100/7 -> hilo_we_o one cycle, lo_o=14, hi_o=2, divzero_o=0; stall_o high from the accept cycle until WB.
REQ-034 DIV 0xFFFFFFF9 (-7) / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
REQ-035 DIV 5/0 -> hilo_we_o=1, divzero_o=1, hi_o=0, lo_o=0.
REQ-036 Flush 10 cycles into RUN -> annul_o single pulse, no hilo_we_o, 2 CANCEL cycles; next request 9/3 gives lo_o=3, hi_o=0.
REQ-037 div_ready_i forced low, TIMEOUT=48 -> timeout_o pulse on RUN cycle 48, no write, return to IDLE.
REQ-038 Two back-to-back DIVU requests (6/4, then 8/3) -> two hilo_we_o pulses, giving (lo,hi)=(1,2) then (2,2); rst pulsed low mid-RUN -> all outputs 0 immediately.
